// File: rtl/pipeline_credit_drain.sv
// Credit-gated output FIFO behind a fixed-latency, non-stallable pipeline.
// Each credit reserves one FIFO slot. Upstream may issue only while a credit
// is held, so every word that leaves the pipeline has a guaranteed slot. The
// FIFO head is then re-presented on a ready/valid interface.
module pipeline_credit_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  issue,
    input  logic                  pipe_valid,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         count,
    output logic                  overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]         credits;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  pop;
    logic                  full;
    logic                  push;

    // Pointers wrap explicitly so that DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready  = (credits != '0) & ~rst;
    assign issue     = in_valid & in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (count == CW'(DEPTH));
    // A push at full succeeds only when it is paired with a pop.
    assign push      = pipe_valid & ~rst & (~full | pop);
    // The head comes straight from storage, so a word written this cycle
    // becomes visible on the next cycle at the earliest.
    assign out_data  = mem[rd_ptr];

    // Credit counter: an issue takes a credit, a pop returns one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CW'(DEPTH);
        end else if (issue & ~pop) begin
            credits <= credits - CW'(1);
        end else if (pop & ~issue) begin
            credits <= credits + CW'(1);
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push & ~pop)      count <= count + CW'(1);
            else if (pop & ~push) count <= count - CW'(1);
        end
    end

    // Storage array; it needs no reset because out_valid qualifies the head.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pipe_data;
    end

    // Sticky error: a word arrived with no free slot, so it was dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (pipe_valid & full & ~pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_credit_drain.sv
// Bench for pipeline_credit_drain. A small pipeline stand-in produces
// pipe_data = issued value + 2. It uses two register stages, so the credit
// round trip (issue -> pipe_valid -> out_valid/pop -> credit back) is exactly
// DEPTH = 4 cycles. Ordering and occupancy are tracked by a queue-based model.
module tb_pipeline_credit_drain;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, issue, out_valid, overflow, pipe_valid;
    logic [DW-1:0] pipe_data, out_data;
    logic [CW-1:0] count;

    logic          inj_v = 1'b0;
    logic [DW-1:0] inj_d = '0;
    logic [1:0]          s_v;
    logic [1:0][DW-1:0]  s_d;
    logic [DW-1:0]       nxt_val;

    int n_chk  = 0;
    int n_fail = 0;

    pipeline_credit_drain #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .issue(issue), .pipe_valid(pipe_valid), .pipe_data(pipe_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Pipeline stand-in: this stage resets with the block.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_v     <= '0;
            s_d     <= '0;
            nxt_val <= '0;
        end else begin
            s_v     <= {s_v[0], issue};
            s_d     <= {s_d[0], nxt_val + DW'(2)};
            if (issue) nxt_val <= nxt_val + DW'(1);
        end
    end
    assign pipe_valid = s_v[1] | inj_v;
    assign pipe_data  = inj_v ? inj_d : s_d[1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // Reference model: a queue of words in FIFO order and an integer credit count.
    logic [DW-1:0] mq[$];
    int            m_cred = DEPTH;
    bit            m_ovf  = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("m_rst_in_ready", in_ready, 0);
                chk("m_rst_issue", issue, 0);
                chk("m_rst_out_valid", out_valid, 0);
                chk("m_rst_count", count, 0);
                chk("m_rst_overflow", overflow, 0);
                mq.delete();
                m_cred = DEPTH;
                m_ovf  = 1'b0;
            end else begin
                bit m_iss, m_pop;
                int n;
                chk("m_in_ready", in_ready, m_cred != 0);
                chk("m_issue", issue, in_valid && m_cred != 0);
                chk("m_out_valid", out_valid, mq.size() != 0);
                chk("m_count", count, mq.size());
                chk("m_overflow", overflow, m_ovf);
                if (mq.size() != 0) chk("m_out_data", out_data, mq[0]);
                m_iss = in_valid && m_cred != 0;
                m_pop = mq.size() != 0 && out_ready;
                n     = mq.size();
                if (m_pop) void'(mq.pop_front());
                if (pipe_valid) begin
                    if (n < DEPTH || m_pop) mq.push_back(pipe_data);
                    else m_ovf = 1'b1;
                end
                m_cred = m_cred + int'(m_pop) - int'(m_iss);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        logic [DW-1:0] got[$];
        int first_iss, first_ov, first_pop, last_pop, stall;

        // Reset held three cycles, then released.
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_in_ready", in_ready, 1);
        step(1);

        // Streaming 0..9 with no backpressure.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        first_iss = -1; first_ov = -1; first_pop = -1; last_pop = -1; stall = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (issue && first_iss < 0) first_iss = c;
            if (out_valid && first_ov < 0) first_ov = c;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
            if (in_valid && !in_ready) stall++;
            step(1);
            if (nxt_val >= 10) in_valid = 1'b0;
        end
        chk("str_n_out", got.size(), 10);
        for (int i = 0; i < got.size(); i++) chk("str_data", got[i], i + 2);
        chk("str_back2back", last_pop - first_pop, 9);
        chk("str_first_lat", first_ov - first_iss, 3);
        chk("str_no_stall", stall, 0);

        // Backpressure: exactly four issues, then drain.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        step(8);
        chk("bp_issues", nxt_val, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_count", count, 4);
        chk("bp_overflow", overflow, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_pop_valid", out_valid, 1);
            chk("bp_pop_data", out_data, i + 2);
            if (i == 0) chk("bp_ready_at_pop", in_ready, 0);
            if (i == 1) chk("bp_ready_after_pop", in_ready, 1);
        end
        step(1);

        // Push and pop together at full.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        step(8);
        in_valid = 1'b0;
        inj_v = 1'b1; inj_d = 32'h55; out_ready = 1'b1;
        @(negedge clk);
        chk("pp_count_before", count, 4);
        chk("pp_head_before", out_data, 2);
        step(1);
        inj_v = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("pp_count_after", count, 4);
        chk("pp_head_after", out_data, 3);
        step(1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pp_drain", out_data, (i < 3) ? i + 3 : 32'h55);
        end
        step(1);

        // Overflow: extra word into a full FIFO is dropped.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        step(8);
        in_valid = 1'b0;
        inj_v = 1'b1; inj_d = 32'hDEAD;
        step(1);
        inj_v = 1'b0;
        @(negedge clk);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 4);
        step(3);
        chk("ovf_sticky", overflow, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ovf_drain", out_data, i + 2);
        end
        step(2);
        chk("ovf_empty", out_valid, 0);
        chk("ovf_still_set", overflow, 1);

        // Reset with two words stored and two in flight.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 10 && count != 2; i++) step(1);
        chk("rm_stored", count, 2);
        chk("rm_in_flight", s_v, 2'b11);
        do_reset();
        @(negedge clk);
        chk("rm_count", count, 0);
        chk("rm_out_valid", out_valid, 0);
        chk("rm_in_ready", in_ready, 1);
        step(4);
        chk("rm_four_issues", nxt_val, 4);
        @(negedge clk);
        chk("rm_credits_out", in_ready, 0);
        step(1);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 49) == 0);
            step(1);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(8);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
